// File: rtl/sec_code_pkg.sv
// sec_code_pkg
// Shared constants, state encoding and the LFSR step function for the
// shortened cyclic Hamming SEC code (28 data bits, 8 check bits). The same
// step function is used by the encoder's divider and by the decoder's
// syndrome logic, so both sides agree on the generator polynomial.
//
// Configuration macro: SEC_ENC_NIBBLE_EN
//   undefined : the divider consumes 1 data bit per step (STEP_BITS = 1)
//   defined   : the divider consumes 4 data bits per step (STEP_BITS = 4)
package sec_code_pkg;

  localparam int K_BITS = 28;
  localparam int P_BITS = 8;
  localparam int W_BITS = K_BITS + P_BITS;

  // x^8 + x^4 + x^3 + x^2 + 1; bit 8 is implicit in the shift register
  localparam logic [8:0] GEN_POLY = 9'h11D;

  localparam int CNT_BITS = $clog2(K_BITS);

`ifdef SEC_ENC_NIBBLE_EN
  localparam int STEP_BITS = 4;
`else
  localparam int STEP_BITS = 1;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } enc_state_t;

  // One step of division by g(x): shift the remainder up by one place and,
  // when the bit leaving the top disagrees with the incoming data bit, fold
  // the low part of the generator back in.
  function automatic logic [P_BITS-1:0] lfsr_step(input logic [P_BITS-1:0] rem,
                                                  input logic data_bit);
    logic fb;
    fb = rem[P_BITS-1] ^ data_bit;
    return {rem[P_BITS-2:0], 1'b0} ^ (fb ? GEN_POLY[P_BITS-1:0] : {P_BITS{1'b0}});
  endfunction

endpackage

// File: rtl/sec_lfsr_div.sv
// sec_lfsr_div
// Remainder register of the polynomial divider. Each enabled edge folds
// STEP_BITS data bits (MSB first) into the remainder.
//
// Configuration macro: SEC_ENC_NIBBLE_EN (selects STEP_BITS via sec_code_pkg)
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset, clears the remainder
//   clear - clears the remainder at the start of a new word
//   step  - advance the remainder by STEP_BITS data bits
//   din   - data bits for this step, din[STEP_BITS-1] processed first
//   rem   - current remainder (the check bits once all data is consumed)
module sec_lfsr_div
  import sec_code_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 step,
  input  logic [STEP_BITS-1:0] din,
  output logic [P_BITS-1:0]    rem
);

  logic [P_BITS-1:0] rem_next;

  // Unrolled chain of single-bit steps; with one bit per step this is just
  // one application of lfsr_step.
  always_comb begin
    rem_next = rem;
    for (int i = STEP_BITS - 1; i >= 0; i--) begin
      rem_next = lfsr_step(rem_next, din[i]);
    end
  end

  // Remainder register; clear wins over step so a new word always starts
  // from an all-zero remainder.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem <= '0;
    end else if (clear) begin
      rem <= '0;
    end else if (step) begin
      rem <= rem_next;
    end
  end

endmodule

// File: rtl/sec_encoder_28bits_clk.sv
// sec_encoder_28bits_clk
// Multi-cycle encoder for the shortened cyclic Hamming SEC code. Latches a
// 28-bit data word, divides D(x)*x^8 by g(x) serially, and presents the
// systematic codeword {D, parity} with a one-cycle valid pulse.
//
// Configuration macro: SEC_ENC_NIBBLE_EN
//   undefined : 1 bit per cycle, start-to-valid latency 29 cycles
//   defined   : 4 bits per cycle, start-to-valid latency 8 cycles
//   Codewords are identical in both builds.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset, highest priority
//   start - encode request, only honoured while ready=1
//   D     - data word, sampled on the accepting edge
//   ready - encoder idle, start is accepted this cycle
//   valid - one-cycle pulse, W holds a new codeword
//   W     - codeword {D_latched, parity[7:0]}, held until the next completion
module sec_encoder_28bits_clk
  import sec_code_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [K_BITS-1:0] D,
  output logic              ready,
  output logic              valid,
  output logic [W_BITS-1:0] W
);

  // Counter start value: index of the first (most significant) step.
  localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(K_BITS / STEP_BITS - 1);

  enc_state_t state, state_next;

  logic [K_BITS-1:0]    d_reg;
  logic [CNT_BITS-1:0]  cnt;
  logic [P_BITS-1:0]    rem;
  logic                 lfsr_clear;
  logic                 lfsr_step_en;
  logic [STEP_BITS-1:0] lfsr_din;
  logic [CNT_BITS+1:0]  shift_amt;
  logic [K_BITS-1:0]    d_shifted;

  // Pick the data bits for this step by shifting them down to the bottom,
  // which avoids a variable part-select on the latched word.
  always_comb begin
`ifdef SEC_ENC_NIBBLE_EN
    shift_amt = {cnt, 2'b00};
`else
    shift_amt = {2'b00, cnt};
`endif
    d_shifted = d_reg >> shift_amt;
    lfsr_din  = d_shifted[STEP_BITS-1:0];
  end

  sec_lfsr_div u_lfsr_div (
    .clk   (clk),
    .rst   (rst),
    .clear (lfsr_clear),
    .step  (lfsr_step_en),
    .din   (lfsr_din),
    .rem   (rem)
  );

  assign ready = (state == IDLE);

  // Next-state and divider control. Leaving SHIFT happens on the edge that
  // processes step 0, so the counter never wraps.
  always_comb begin
    state_next   = state;
    lfsr_clear   = 1'b0;
    lfsr_step_en = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          lfsr_clear = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        lfsr_step_en = 1'b1;
        if (cnt == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register plus the datapath registers it controls. An aborting
  // reset clears W as well, so no stale codeword survives a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      d_reg <= '0;
      cnt   <= '0;
      W     <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_next;
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            d_reg <= D;
            cnt   <= CNT_INIT;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          W     <= {d_reg, rem};
          valid <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sec_encoder_28bits_clk.sv
// tb_sec_encoder_28bits_clk
// Scoreboard bench for sec_encoder_28bits_clk: stimulus pushes the expected
// codeword and its due cycle, a monitor pops and compares on every valid.
module tb_sec_encoder_28bits_clk;
  import sec_code_pkg::*;

`ifdef SEC_ENC_NIBBLE_EN
  localparam int LAT = 8;
`else
  localparam int LAT = 29;
`endif

  logic              clk;
  logic              rst;
  logic              start;
  logic [K_BITS-1:0] D;
  logic              ready;
  logic              valid;
  logic [W_BITS-1:0] W;

  typedef struct {
    logic [W_BITS-1:0] w;
    int                due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cycle      = 0;
  int   num_checks = 0;
  int   num_fail   = 0;

  sec_encoder_28bits_clk dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .D     (D),
    .ready (ready),
    .valid (valid),
    .W     (W)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle stamp, used to check start-to-valid latency.
  always @(posedge clk) cycle <= cycle + 1;

  // Independent parity model: XOR of x^(8+i) mod g(x) over the set data bits.
  function automatic logic [P_BITS-1:0] model_parity(input logic [K_BITS-1:0] d);
    logic [P_BITS-1:0] p;
    logic [P_BITS-1:0] r;
    p = '0;
    r = 8'h1D;
    for (int i = 0; i < K_BITS; i++) begin
      if (d[i]) p = p ^ r;
      r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        num_checks++;
        num_fail++;
        $display("[TB] FAIL unexpected_valid: got valid with W=%h, expected no valid", W);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("codeword", 64'(W), 64'(mon_e.w));
        checkOutput("latency", 64'(cycle), 64'(mon_e.due));
      end
    end
  end

  // Called at a negedge. Waits (bounded) for ready, presents the word and
  // returns at the negedge after the accepting edge.
  task automatic applyStimulus(input logic [K_BITS-1:0] d, input logic [W_BITS-1:0] w_exp,
                               input bit push, input bit hold);
    int waited = 0;
    while (ready !== 1'b1 && waited < 2 * LAT + 10) begin
      D = K_BITS'($urandom);
      @(negedge clk);
      waited++;
    end
    if (ready !== 1'b1) begin
      checkOutput("ready_timeout", 64'(ready), 64'd1);
      return;
    end
    start = 1'b1;
    D     = d;
    if (push) sb.push_back('{w_exp, cycle + 1 + LAT});
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 1'b0;
    checkOutput("ready_busy", 64'(ready), 64'd0);
  endtask

  task automatic drain();
    int waited = 0;
    while (sb.size() != 0 && waited < LAT + 40) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("drain_pending", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  logic [K_BITS-1:0] vec_d[4] = '{28'h0000001, 28'h0000002, 28'h0000003, 28'h0000080};
  logic [W_BITS-1:0] vec_w[4] = '{36'h0_0000_011D, 36'h0_0000_023A, 36'h0_0000_0327,
                                  36'h0_0000_8026};

  initial begin
    logic [K_BITS-1:0] rd;
    rst   = 1'b1;
    start = 1'b0;
    D     = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_W", 64'(W), 64'd0);
    checkOutput("reset_valid", 64'(valid), 64'd0);
    checkOutput("reset_ready", 64'(ready), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    // Zero word, with ready watched for the whole operation.
    applyStimulus(28'h0, 36'h0, 1'b1, 1'b0);
    for (int i = 1; i < LAT; i++) begin
      @(negedge clk);
      checkOutput("ready_low", 64'(ready), 64'd0);
    end
    drain();

    // Hand-computed vectors; the last one gets a busy-time start to ignore.
    for (int v = 0; v < 4; v++) begin
      applyStimulus(vec_d[v], vec_w[v], 1'b1, 1'b0);
      if (v == 3) begin
        repeat (5) @(negedge clk);
        start = 1'b1;
        D     = 28'hFFFFFFF;
        @(negedge clk);
        start = 1'b0;
      end
      drain();
    end
    repeat (3) @(negedge clk);

    // Reset in the middle of an operation aborts it silently.
    applyStimulus(28'h0000001, 36'h0, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_W", 64'(W), 64'd0);
    checkOutput("abort_valid", 64'(valid), 64'd0);
    checkOutput("abort_ready", 64'(ready), 64'd1);
    repeat (LAT + 5) @(negedge clk);
    checkOutput("abort_W_held", 64'(W), 64'd0);
    applyStimulus(28'h0000001, 36'h0_0000_011D, 1'b1, 1'b0);
    drain();

    // Back-to-back random words with start held high.
    for (int n = 0; n < 1000; n++) begin
      rd = K_BITS'($urandom);
      applyStimulus(rd, {rd, model_parity(rd)}, 1'b1, 1'b1);
    end
    start = 1'b0;
    drain();
    repeat (LAT + 5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_fail);
    $finish;
  end

endmodule
